// File: rtl/des_dec_key_sched_if.sv
// Handshake/key bus between the DES round engine and the subkey scheduler.
// enc_mode exists only when DES_ENC_MODE_EN is defined.
interface des_dec_key_sched_if;
    logic [1:64] key_in;
    logic        key_load;
    logic        subkey_ready;
    logic [1:48] subkey_out;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        done;
    logic        key_err;
`ifdef DES_ENC_MODE_EN
    logic        enc_mode;

    modport master (
        output key_in, key_load, subkey_ready, enc_mode,
        input  subkey_out, subkey_valid, round_idx, done, key_err
    );
    modport slave (
        input  key_in, key_load, subkey_ready, enc_mode,
        output subkey_out, subkey_valid, round_idx, done, key_err
    );
`else
    modport master (
        output key_in, key_load, subkey_ready,
        input  subkey_out, subkey_valid, round_idx, done, key_err
    );
    modport slave (
        input  key_in, key_load, subkey_ready,
        output subkey_out, subkey_valid, round_idx, done, key_err
    );
`endif
endinterface

// File: rtl/des_dec_key_sched.sv
// Iterative DES subkey generator: K16..K1 by right-rotating C/D after PC-1, one subkey per accept.
// Optional DES_ENC_MODE_EN adds enc_mode (K1..K16 via left rotations). PARITY_CHK=1 rejects even-parity key bytes.
module des_dec_key_sched #(
    parameter int unsigned PARITY_CHK = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    des_dec_key_sched_if.slave        bus
);

    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    // All vectors use DES numbering: index 1 is the MSB.
    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) r[6'(i + 1)] = k[7'(PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) r[6'(i + 1)] = cd[6'(PC2_TAB[i])];
        return r;
    endfunction

    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:28] rot28(input logic [1:28] h, input logic [1:0] amt, input logic left);
        logic [1:28] r;
        r = h;
        if (left) begin
            if (amt == 2'd1)      r = {h[2:28], h[1]};
            else if (amt == 2'd2) r = {h[3:28], h[1:2]};
        end else begin
            if (amt == 2'd1)      r = {h[28], h[1:27]};
            else if (amt == 2'd2) r = {h[27:28], h[1:26]};
        end
        return r;
    endfunction

    function automatic logic [1:56] rot56(input logic [1:56] cd, input logic [1:0] amt, input logic left);
        return {rot28(cd[1:28], amt, left), rot28(cd[29:56], amt, left)};
    endfunction

    function automatic logic parity_ok(input logic [1:64] k);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = 0; b < 8; b++) ok = ok & (^k[7'(8 * b + 1) +: 8]);
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [1:56] cd_q, cd_d;
    logic [4:0]  step_q, step_d;
    logic [1:48] sk_q, sk_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        key_ok;

`ifdef DES_ENC_MODE_EN
    logic        enc_q, enc_d;
`else
    logic        enc_q;
    assign enc_q = 1'b0;
`endif

    assign key_ok = (PARITY_CHK == 0) || parity_ok(bus.key_in);

    // The first RUN cycle (valid low) registers the first subkey; each accept then
    // rotates C/D and registers the next subkey on the same edge.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        step_d  = step_q;
        sk_d    = sk_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef DES_ENC_MODE_EN
        enc_d   = enc_q;
`endif
        if (bus.key_load) begin
            valid_d = 1'b0;
            if (key_ok) begin
                cd_d    = pc1(bus.key_in);
                step_d  = 5'd1;
                state_d = RUN;
                err_d   = 1'b0;
`ifdef DES_ENC_MODE_EN
                enc_d   = bus.enc_mode;
`endif
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (!valid_q) begin
                cd_d    = enc_q ? rot56(cd_q, shift_amt(step_q), 1'b1) : cd_q;
                sk_d    = pc2(cd_d);
                valid_d = 1'b1;
                idx_d   = enc_q ? 4'(step_q - 5'd1) : 4'(5'd16 - step_q);
            end else if (bus.subkey_ready) begin
                if (step_q == 5'd16) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + 5'd1;
                    cd_d   = enc_q ? rot56(cd_q, shift_amt(step_d), 1'b1)
                                   : rot56(cd_q, shift_amt(5'd17 - step_q), 1'b0);
                    sk_d   = pc2(cd_d);
                    idx_d  = enc_q ? 4'(step_q) : 4'(5'd15 - step_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            step_q  <= '0;
            sk_q    <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef DES_ENC_MODE_EN
            enc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            step_q  <= step_d;
            sk_q    <= sk_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef DES_ENC_MODE_EN
            enc_q   <= enc_d;
`endif
        end
    end

    assign bus.subkey_out   = sk_q;
    assign bus.subkey_valid = valid_q;
    assign bus.round_idx    = idx_q;
    assign bus.done         = done_q;
    assign bus.key_err      = err_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched: golden DES vectors plus random keys against a
// forward-computed key-schedule model.
module tb_des_dec_key_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_dec_key_sched_if bus ();

    des_dec_key_sched #(.PARITY_CHK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  idx;
    } vec_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_T1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [47:0] gold_k [16];
    logic [47:0] mk [1:16];
    vec_t        exp_q [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard forward schedule K1..K16: cumulative left shifts on 28-bit halves.
    task automatic build_model(input logic [63:0] key);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        c = '0;
        d = '0;
        for (int i = 0; i < 28; i++) c = {c[26:0], key[6'(64 - PC1_T[i])]};
        for (int i = 28; i < 56; i++) d = {d[26:0], key[6'(64 - PC1_T[i])]};
        for (int r = 1; r <= 16; r++) begin
            c  = (c << SHIFTS[r - 1]) | (c >> (28 - SHIFTS[r - 1]));
            d  = (d << SHIFTS[r - 1]) | (d >> (28 - SHIFTS[r - 1]));
            cd = {c, d};
            k  = '0;
            for (int i = 0; i < 48; i++) k = {k[46:0], cd[6'(56 - PC2_T[i])]};
            mk[r] = k;
        end
    endtask

    task automatic set_exp_model(input logic [63:0] key, input logic enc);
        build_model(key);
        for (int r = 0; r < 16; r++) begin
            if (enc) exp_q[r] = '{mk[r + 1], 4'(r)};
            else     exp_q[r] = '{mk[16 - r], 4'(15 - r)};
        end
    endtask

    task automatic set_exp_gold(input logic enc);
        for (int r = 0; r < 16; r++) begin
            if (enc) exp_q[r] = '{gold_k[r], 4'(r)};
            else     exp_q[r] = '{gold_k[15 - r], 4'(15 - r)};
        end
    endtask

    function automatic logic [63:0] odd_par(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) r[8 * b] = ~^r[8 * b + 1 +: 7];
        return r;
    endfunction

    task automatic load_key(input logic [63:0] key, input logic enc);
        bus.key_in   = key;
        bus.key_load = 1'b1;
`ifdef DES_ENC_MODE_EN
        bus.enc_mode = enc;
`endif
        tick();
        bus.key_load = 1'b0;
    endtask

    // mode 0: ready always 1, 1: toggle 1/0, 2: random. Must follow load_key directly.
    task automatic collect(input int mode, input int n_acc, input string tag);
        int          got;
        int          cyc;
        logic        rdy;
        logic        held;
        logic [47:0] h_sk;
        logic [3:0]  h_idx;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        check({tag, " lat0 valid"}, bus.subkey_valid, 0);
        check({tag, " lat0 done"}, bus.done, 0);
        tick();
        check({tag, " lat1 valid"}, bus.subkey_valid, 1);
        while (got < n_acc && cyc < 200) begin
            if (held) begin
                check({tag, " hold subkey"}, bus.subkey_out, h_sk);
                check({tag, " hold idx"}, bus.round_idx, h_idx);
                check({tag, " hold valid"}, bus.subkey_valid, 1);
                held = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.subkey_ready = rdy;
            check({tag, " done low"}, bus.done, 0);
            if (bus.subkey_valid) begin
                if (rdy) begin
                    check({tag, " subkey"}, bus.subkey_out, exp_q[got].sk);
                    check({tag, " round_idx"}, bus.round_idx, exp_q[got].idx);
                    got++;
                end else begin
                    held  = 1'b1;
                    h_sk  = bus.subkey_out;
                    h_idx = bus.round_idx;
                end
            end
            tick();
            cyc++;
        end
        check({tag, " accepts"}, got, n_acc);
        if (mode == 0) check({tag, " cycles"}, cyc, n_acc);
        bus.subkey_ready = 1'b0;
        if (n_acc == 16) begin
            check({tag, " done pulse"}, bus.done, 1);
            check({tag, " valid after K1"}, bus.subkey_valid, 0);
            tick();
            check({tag, " done cleared"}, bus.done, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] key;
        logic        enc;
        int          mode;

        gold_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                   48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                   48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                   48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

        rst              = 1'b1;
        bus.key_in       = '0;
        bus.key_load     = 1'b0;
        bus.subkey_ready = 1'b0;
`ifdef DES_ENC_MODE_EN
        bus.enc_mode     = 1'b0;
`endif
        tick();
        tick();
        check("reset valid", bus.subkey_valid, 0);
        check("reset subkey", bus.subkey_out, 0);
        check("reset idx", bus.round_idx, 0);
        check("reset done", bus.done, 0);
        check("reset key_err", bus.key_err, 0);
        rst = 1'b0;
        tick();

        // T1: golden schedule, back-to-back accepts
        set_exp_gold(1'b0);
        load_key(KEY_T1, 1'b0);
        collect(0, 16, "T1");

        // T2: ready toggling
        load_key(KEY_T1, 1'b0);
        collect(1, 16, "T2");

        // T3: abort after 5 accepts, restart on a new key
        load_key(KEY_T1, 1'b0);
        collect(0, 5, "T3a");
        check("T3a idx before abort", bus.round_idx, 10);
        check("T3a subkey before abort", bus.subkey_out, gold_k[10]);
        key = odd_par({$urandom, $urandom});
        set_exp_model(key, 1'b0);
        load_key(key, 1'b0);
        collect(0, 16, "T3b");

        // Reload coinciding with the final accept
        set_exp_gold(1'b0);
        load_key(KEY_T1, 1'b0);
        collect(0, 15, "T3c");
        check("T3c idx at K1", bus.round_idx, 0);
        key = odd_par({$urandom, $urandom});
        set_exp_model(key, 1'b0);
        bus.subkey_ready = 1'b1;
        load_key(key, 1'b0);
        collect(0, 16, "T3d");

        // T4: asynchronous reset mid-schedule
        set_exp_gold(1'b0);
        load_key(KEY_T1, 1'b0);
        collect(0, 8, "T4a");
        check("T4 idx before reset", bus.round_idx, 7);
        #2 rst = 1'b1;
        #1;
        check("T4 async valid", bus.subkey_valid, 0);
        check("T4 async subkey", bus.subkey_out, 0);
        check("T4 async idx", bus.round_idx, 0);
        #1 rst = 1'b0;
        tick();
        load_key(KEY_T1, 1'b0);
        collect(0, 16, "T4b");

        // T5: parity rejection, then good reload
        load_key(KEY_BAD, 1'b0);
        check("T5 key_err set", bus.key_err, 1);
        check("T5 valid low", bus.subkey_valid, 0);
        tick();
        tick();
        check("T5 key_err sticky", bus.key_err, 1);
        check("T5 still idle", bus.subkey_valid, 0);
        load_key(KEY_T1, 1'b0);
        check("T5 key_err cleared", bus.key_err, 0);
        collect(2, 16, "T5");

        // Random keys against the reference model
        for (int t = 0; t < 6; t++) begin
            key  = odd_par({$urandom, $urandom});
            mode = int'($urandom_range(0, 2));
            enc  = 1'b0;
`ifdef DES_ENC_MODE_EN
            enc  = 1'($urandom_range(0, 1));
`endif
            set_exp_model(key, enc);
            load_key(key, enc);
            collect(mode, 16, "RND");
        end

`ifdef DES_ENC_MODE_EN
        // T6: encrypt order against the golden table
        set_exp_gold(1'b1);
        load_key(KEY_T1, 1'b1);
        collect(0, 16, "T6");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
